// File: rtl/periph_div_pkg.sv
// Shared constants and types for the memory-mapped divider peripheral.
package periph_div_pkg;

  localparam int DIV_W = 32;

  // Register select on bus address bits [3:2]
  localparam logic [1:0] DIV_ADDR_STATUS  = 2'd0;
  localparam logic [1:0] DIV_ADDR_DIVISOR = 2'd1;
  localparam logic [1:0] DIV_ADDR_QUOT    = 2'd2;
  localparam logic [1:0] DIV_ADDR_REM     = 2'd3;

  // Bit positions inside the status word
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DZ_BIT   = 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/div_core.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the start cycle
// BUSY  | 32 iterations in flight; done pulses on the final iteration
//
// quotient/remainder present the value being written into the working
// registers, so the caller can capture the final result on the same edge
// that the last iteration completes.
module div_core
  import periph_div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIV_W-1:0]  dividend,
  input  logic [DIV_W-1:0]  divisor,
  output logic              busy,
  output logic              done,
  output logic [DIV_W-1:0]  quotient,
  output logic [DIV_W-1:0]  remainder
);

  div_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DIV_W-1:0]  dvd_q, dvd_d;
  logic [DIV_W-1:0]  dvs_q, dvs_d;
  logic [DIV_W-1:0]  rem_q, rem_d;
  logic [DIV_W-1:0]  quo_q, quo_d;

  logic [DIV_W:0]    partial;
  logic [DIV_W-1:0]  diff;
  logic              borrow;

  // State and datapath registers; reset clears everything including a run in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
    end
  end

  // Next-state and one restoring step: trial-subtract the divisor from {rem, next dividend bit}
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    done    = 1'b0;

    partial = {rem_q, dvd_q[DIV_W-1]};
    borrow  = (partial < {1'b0, dvs_q});
    // When there is no borrow the difference is below the divisor, so 32 bits hold it
    diff    = partial[DIV_W-1:0] - dvs_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = '0;
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          quo_d   = '0;
        end
      end
      BUSY: begin
        rem_d = borrow ? partial[DIV_W-1:0] : diff;
        quo_d = {quo_q[DIV_W-2:0], ~borrow};
        dvd_d = {dvd_q[DIV_W-2:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == BUSY);
  assign quotient  = quo_d;
  assign remainder = rem_d;

endmodule

// File: rtl/periph_divider.sv
// Bus responder for the divider: register decode, stall handshake and divide-by-zero shortcut.
module periph_divider
  import periph_div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic              valid_stall_i,
  input  logic [DIV_W-1:0]  wdata,
  output logic [DIV_W-1:0]  rdata,
  output logic              valid_o
);

  logic [DIV_W-1:0] dividend_q, dividend_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic [DIV_W-1:0] quot_q, quot_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic             wr_acc;
  logic             core_start;
  logic             core_busy;
  logic             core_done;
  logic [DIV_W-1:0] core_quot;
  logic [DIV_W-1:0] core_rem;
  logic [DIV_W-1:0] status;

  div_core u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .dividend  (dividend_q),
    .divisor   (wdata),
    .busy      (core_busy),
    .done      (core_done),
    .quotient  (core_quot),
    .remainder (core_rem)
  );

  // Handshake: hold the requester off anything that would disturb or read an unfinished result
  always_comb begin
    valid_o = 1'b0;
    if (ce) begin
      valid_o = 1'b1;
      if (core_busy) begin
        if (we && (addr == DIV_ADDR_STATUS || addr == DIV_ADDR_DIVISOR)) valid_o = 1'b0;
        if (!we && (addr == DIV_ADDR_QUOT || addr == DIV_ADDR_REM)) valid_o = 1'b0;
      end
    end
  end

  assign wr_acc     = ce & we & valid_o & ~valid_stall_i;
  assign core_start = wr_acc && (addr == DIV_ADDR_DIVISOR) && (wdata != '0);

  // Register updates from accepted writes, core completion and the divide-by-zero path
  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dz_d       = dz_q;

    if (core_done) begin
      quot_d = core_quot;
      rem_d  = core_rem;
    end

    if (wr_acc) begin
      case (addr)
        DIV_ADDR_STATUS:  dividend_d = wdata;
        DIV_ADDR_DIVISOR: begin
          divisor_d = wdata;
          if (wdata == '0) begin
            dz_d   = 1'b1;
            quot_d = '1;
            rem_d  = dividend_q;
          end else begin
            dz_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus-visible registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dz_q       <= 1'b0;
    end else begin
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dz_q       <= dz_d;
    end
  end

  // Read mux, combinational from addr
  always_comb begin
    status                = '0;
    status[STAT_BUSY_BIT] = core_busy;
    status[STAT_DZ_BIT]   = dz_q;
    case (addr)
      DIV_ADDR_STATUS:  rdata = status;
      DIV_ADDR_DIVISOR: rdata = divisor_q;
      DIV_ADDR_QUOT:    rdata = quot_q;
      default:          rdata = rem_q;
    endcase
  end

endmodule

// File: tb/tb_periph_divider.sv
// Directed bench for periph_divider: reads push expected data into a queue,
// a negedge monitor pops and compares whenever a read completes.
module tb_periph_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        we;
  logic [1:0]  addr;
  logic        valid_stall_i;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        valid_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  periph_divider dut (
    .clk           (clk),
    .reset         (reset),
    .ce            (ce),
    .we            (we),
    .addr          (addr),
    .valid_stall_i (valid_stall_i),
    .wdata         (wdata),
    .rdata         (rdata),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every completed read is compared with the oldest expectation
  always @(negedge clk) begin
    if (!reset && ce && !we && valid_o) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: read of addr %0d returned 0x%08h with nothing expected", addr, rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e.data) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, rdata, e.data);
        end
      end
    end
  end

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input int exp_stall, input string nm);
    int st;
    bit ok;
    exp_t e;
    st = 0;
    ok = 1'b0;
    e.name = nm;
    e.data = exp;
    exp_q.push_back(e);
    ce = 1'b1; we = 1'b0; addr = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
      st++;
    end
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: valid_o never rose within 100 cycles", nm);
      void'(exp_q.pop_back());
    end else if (exp_stall >= 0) begin
      check({nm, "_stall"}, st, exp_stall);
    end
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input int exp_stall, input string nm);
    int st;
    bit ok;
    st = 0;
    ok = 1'b0;
    ce = 1'b1; we = 1'b1; addr = a; wdata = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
      st++;
    end
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: write never accepted within 100 cycles", nm);
    end else if (exp_stall >= 0) begin
      check({nm, "_stall"}, st, exp_stall);
    end
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; we = 1'b0; addr = 2'd0; valid_stall_i = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state with ce low
    @(negedge clk);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    bus_read(2'd0, 32'h0, 0, "rst_status");
    bus_read(2'd2, 32'h0, 0, "rst_quot");

    // 100 / 7
    bus_write(2'd0, 32'd100, 0, "wr_dvd100");
    bus_write(2'd1, 32'd7, 0, "wr_dvs7");
    bus_read(2'd2, 32'd14, 32, "q_100_7");
    bus_read(2'd3, 32'd2, 0, "r_100_7");
    bus_read(2'd1, 32'd7, 0, "rd_divisor");
    bus_read(2'd0, 32'h0, 0, "status_idle");

    // 0xFFFFFFFF / 1
    bus_write(2'd0, 32'hFFFF_FFFF, 0, "wr_dvd_max");
    bus_write(2'd1, 32'd1, 0, "wr_dvs1");
    bus_read(2'd2, 32'hFFFF_FFFF, 32, "q_max_1");
    bus_read(2'd3, 32'd0, 0, "r_max_1");

    // 5 / 9, with busy status read mid-flight
    bus_write(2'd0, 32'd5, 0, "wr_dvd5");
    bus_write(2'd1, 32'd9, 0, "wr_dvs9");
    bus_read(2'd0, 32'h1, 0, "status_busy");
    bus_read(2'd2, 32'd0, 31, "q_5_9");
    bus_read(2'd3, 32'd5, 0, "r_5_9");

    // Divide by zero, then recovery
    bus_write(2'd0, 32'd42, 0, "wr_dvd42");
    bus_write(2'd1, 32'd0, 0, "wr_dvs0");
    bus_read(2'd0, 32'h2, 0, "status_dz");
    bus_read(2'd2, 32'hFFFF_FFFF, 0, "q_dz");
    bus_read(2'd3, 32'd42, 0, "r_dz");
    bus_write(2'd2, 32'hDEAD_BEEF, 0, "wr_quot_ign");
    bus_write(2'd3, 32'h1234_5678, 0, "wr_rem_ign");
    bus_read(2'd2, 32'hFFFF_FFFF, 0, "q_after_ign");
    bus_read(2'd3, 32'd42, 0, "r_after_ign");
    bus_write(2'd0, 32'd10, 0, "wr_dvd10");
    bus_write(2'd1, 32'd3, 0, "wr_dvs3");
    bus_read(2'd2, 32'd3, 32, "q_10_3");
    bus_read(2'd3, 32'd1, 0, "r_10_3");
    bus_read(2'd0, 32'h0, 0, "status_dz_clr");

    // Dividend write while busy is held; operands already latched
    bus_write(2'd0, 32'd1000, 0, "wr_dvd1000");
    bus_write(2'd1, 32'd10, 0, "wr_dvs10");
    repeat (14) @(posedge clk);
    #1;
    bus_write(2'd0, 32'd7, 18, "wr_dvd7_busy");
    bus_read(2'd2, 32'd100, 0, "q_1000_10");
    bus_read(2'd3, 32'd0, 0, "r_1000_10");
    bus_write(2'd1, 32'd1, 0, "wr_dvs1_b");
    bus_read(2'd2, 32'd7, 32, "q_new_dvd");

    // Back-to-back start held until IDLE
    bus_write(2'd0, 32'd100, 0, "wr_dvd100_b");
    bus_write(2'd1, 32'd7, 0, "wr_dvs7_b");
    bus_write(2'd1, 32'd1, 32, "wr_dvs1_b2b");
    bus_read(2'd2, 32'd100, 32, "q_b2b");
    bus_read(2'd3, 32'd0, 0, "r_b2b");

    // Reset mid-division
    bus_write(2'd0, 32'd1000, 0, "wr_dvd1000_r");
    bus_write(2'd1, 32'd10, 0, "wr_dvs10_r");
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'b0, valid_o}, 32'd0);
    @(posedge clk); #1;
    bus_read(2'd0, 32'h0, 0, "rst_mid_status");
    bus_read(2'd2, 32'h0, 0, "rst_mid_quot");
    bus_read(2'd3, 32'h0, 0, "rst_mid_rem");
    bus_read(2'd1, 32'h0, 0, "rst_mid_dvs");

    // Start write held by valid_stall_i for 3 cycles must start exactly once
    bus_write(2'd0, 32'd50, 0, "wr_dvd50");
    ce = 1'b1; we = 1'b1; addr = 2'd1; wdata = 32'd9; valid_stall_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    valid_stall_i = 1'b0;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
    bus_read(2'd0, 32'h1, 0, "status_stall_start");
    bus_read(2'd2, 32'd5, 31, "q_50_9");
    bus_read(2'd3, 32'd5, 0, "r_50_9");
    bus_read(2'd0, 32'h0, 0, "status_stall_end");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected reads never observed", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/periph_divider.md
# periph_divider

Memory-mapped unsigned 32-bit sequential divider on the data-memory-stage peripheral bus. It is the responder end of the ce/we/addr/wdata/rdata/valid_o handshake that the MEM stage drives for addresses ≥ 512. Long operations are covered by holding `valid_o` low, so the MEM stage raises its stall until the result is ready. Operands are written, the division is started by the divisor write, and quotient and remainder are read back.

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `ce`  in  1  chip enable; access present this cycle.
- `we`  in  1  write enable (already gated by pipeline stall upstream).
- `addr`  in  2  register select (bus address bits [3:2]).
- `valid_stall_i`  in  1  registered pipeline hold from hazard logic; when 1, writes have no side effect.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational from `addr` and registers.
- `valid_o`  out  1  access complete this cycle; 0 means the requester must hold.

## Operation
- Register map:
  - addr 0: write = dividend; read = status {30'b0, dz, busy}.
  - addr 1: write = divisor, and starts a division.
  - addr 2: read = quotient.
  - addr 3: read = remainder.
  - Writes to 2/3 are ignored. Reads of 1 return the divisor.
- States: IDLE, BUSY.
  - IDLE→BUSY on an accepted addr-1 write with nonzero divisor.
  - BUSY→IDLE after 32 iterations.
- Write acceptance: `ce & we & valid_o & ~valid_stall_i`. Only accepted writes update registers or start work.
- `valid_o` (only meaningful when `ce`=1):
  - 0 when BUSY and the access is a write to 0/1 or a read of 2/3.
  - 1 otherwise, including reads of addr 0 while BUSY.
  - `valid_o`=0 whenever `ce`=0.
- Datapath: restoring division, one quotient bit per cycle, MSB first.
  - Per cycle: 33-bit partial remainder = {rem[31:0], dividend bit}, minus {1'b0, divisor}.
  - Quotient bit = no borrow; keep the difference if no borrow.
  - Operands are latched at start, so later dividend writes cannot corrupt work in flight.
- Divide by zero (accepted addr-1 write with `wdata`=0):
  - No BUSY: quotient = 0xFFFFFFFF, remainder = dividend, dz=1, all at the next edge.
  - dz clears on the next accepted start with nonzero divisor.
- Reset (any time, including mid-BUSY):
  - state IDLE, all registers 0, dz=0, iteration count 0.
  - `rdata`=0, `valid_o`=0 with `ce`=0.

## Timing
- Reads in IDLE and writes of addr 0 in IDLE: `valid_o`=1 in the same cycle; zero added latency.
- Start write accepted at edge E0. BUSY during cycles E0..E32. Result registers final at edge E32; IDLE from E32.
- A read of addr 2/3 issued right after start sees `valid_o`=0 for 32 cycles, then 1 with the final value.
- Status `busy` reads 1 during those 32 cycles.
- Back-to-back start while BUSY is held (`valid_o`=0) and accepted in the first IDLE cycle. No start is ever dropped or duplicated.
- `ce` held across multiple cycles by a stalled pipeline (`valid_stall_i`=1) causes no repeated writes.
- Iteration counter is 5 bits plus done; no wrap beyond 32.

## Structure
- Package `periph_div_pkg`:
  - address constants `DIV_ADDR_STATUS/DIVISOR/QUOT/REM`.
  - state enum {IDLE, BUSY}.
  - status bit indices.
- Sub-module `div_core`: iterative restoring datapath (start, dividend, divisor → quotient, remainder, done). `periph_divider` holds bus decode, handshake, and the divide-by-zero path.
- Expected size: ~200 lines total.

## Test plan
- Write dividend 100, divisor 7, then read addr 2 immediately → `valid_o` low 32 cycles, then quotient 14; read addr 3 → 2 with `valid_o`=1 same cycle.
- Dividend 0xFFFFFFFF, divisor 1 → quotient 0xFFFFFFFF, remainder 0. Dividend 5, divisor 9 → quotient 0, remainder 5.
- Dividend 42, divisor 0 → next cycle status = 0x2, quotient 0xFFFFFFFF, remainder 42, no stall. Then 10/3 → dz cleared, q=3, r=1.
- Start 1000/10, then at iteration 15 write dividend 7 → write stalled until IDLE. Quotient 100 unaffected; dividend becomes 7 after completion.
- Start division, assert `reset` at iteration 10 → next cycle status 0, quotient 0, remainder 0. A read of addr 2 returns 0 with `valid_o`=1.
- Hold `ce`/`we`/addr 1 for 3 cycles with `valid_stall_i`=1, then 0 → exactly one start, busy 32 cycles.
